user_port_arbiter: RTL and testbench

USER_PORT_ARBITER -- requirements
Module: user_port_arbiter

---
 rtl/user_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_user_port_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_port_arbiter.sv
// Two-requester (Wishbone slave + Logic Analyzer) round-robin arbiter for a single
// shared resource port, with a per-access ack timeout and a sticky timeout IRQ.
module user_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              la_req_i,
  input  logic              la_we_i,
  input  logic [ADDR_W-1:0] la_addr_i,
  input  logic [31:0]       la_wdata_i,
  output logic              la_done_o,
  output logic [31:0]       la_rdata_o,
  output logic              res_req_o,
  output logic              res_we_o,
  output logic [ADDR_W-1:0] res_addr_o,
  output logic [3:0]        res_sel_o,
  output logic [31:0]       res_wdata_o,
  input  logic              res_ack_i,
  input  logic [31:0]       res_rdata_i,
  output logic [2:0]        user_irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0]  CNT_LAST     = 8'(TIMEOUT - 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  state_t              state_q, state_d;
  logic                la_prev_q;
  logic                la_pend_q, la_pend_d;
  logic                last_wb_q, last_wb_d;
  logic                gnt_wb_q, gnt_wb_d;
  logic                cyc_ok_q, cyc_ok_d;
  logic                local_q, local_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                irq_q, irq_d;
  logic [31:0]         wbs_dat_q, wbs_dat_d;
  logic [31:0]         la_rdata_q, la_rdata_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                wb_req;
  logic                la_edge;
  logic                la_busy;
  logic                grant_wb;
  logic                wb_ack;
  logic [ADDR_W-1:0]   wb_addr;
  logic                unused_adr_bits;

  assign wb_req          = wbs_cyc_i & wbs_stb_i;
  assign wb_addr         = wbs_adr_i[ADDR_W+1:2];
  assign la_edge         = la_req_i & ~la_prev_q;
  assign la_busy         = (state_q != IDLE) & ~gnt_wb_q;
  assign unused_adr_bits = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

  // Ack qualification is fully registered so a master dropping cyc on seeing ack
  // cannot shorten the pulse.
  assign wb_ack      = (state_q == RESP) & gnt_wb_q & cyc_ok_q;
  assign wbs_ack_o   = wb_ack;
  assign la_done_o   = (state_q == RESP) & ~gnt_wb_q;
  assign wbs_dat_o   = wbs_dat_q;
  assign la_rdata_o  = la_rdata_q;
  assign res_req_o   = (state_q == BUSY) & ~local_q;
  assign res_we_o    = we_q;
  assign res_addr_o  = addr_q;
  assign res_sel_o   = sel_q;
  assign res_wdata_o = wdata_q;
  assign user_irq    = {2'b00, irq_q};

  always_comb begin
    state_d    = state_q;
    la_pend_d  = la_pend_q;
    last_wb_d  = last_wb_q;
    gnt_wb_d   = gnt_wb_q;
    cyc_ok_d   = cyc_ok_q;
    local_d    = local_q;
    cnt_d      = cnt_q;
    irq_d      = irq_q;
    wbs_dat_d  = wbs_dat_q;
    la_rdata_d = la_rdata_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    grant_wb   = 1'b0;

    if (la_edge && !la_pend_q && !la_busy) la_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (wb_req || la_pend_q) begin
          grant_wb  = wb_req && (!la_pend_q || !last_wb_q);
          state_d   = BUSY;
          cnt_d     = 8'd0;
          gnt_wb_d  = grant_wb;
          last_wb_d = grant_wb;
          if (grant_wb) begin
            we_d     = wbs_we_i;
            addr_d   = wb_addr;
            sel_d    = wbs_sel_i;
            wdata_d  = wbs_dat_i;
            cyc_ok_d = 1'b1;
            // IRQ-clear write is serviced locally and never reaches the resource.
            local_d  = wbs_we_i & wbs_dat_i[31] & (&wb_addr);
          end else begin
            we_d      = la_we_i;
            addr_d    = la_addr_i;
            sel_d     = 4'hF;
            wdata_d   = la_wdata_i;
            cyc_ok_d  = 1'b0;
            local_d   = 1'b0;
            la_pend_d = 1'b0;
          end
        end
      end
      BUSY: begin
        cyc_ok_d = cyc_ok_q & wbs_cyc_i;
        if (local_q) begin
          state_d = RESP;
        end else if (res_ack_i) begin
          state_d = RESP;
          if (gnt_wb_q) wbs_dat_d = res_rdata_i;
          else          la_rdata_d = res_rdata_i;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          irq_d   = 1'b1;
          if (gnt_wb_q) wbs_dat_d = TIMEOUT_DATA;
          else          la_rdata_d = TIMEOUT_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (local_q && wb_ack) irq_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    la_prev_q <= la_req_i;
    if (wb_rst_i) begin
      state_q    <= IDLE;
      la_pend_q  <= 1'b0;
      last_wb_q  <= 1'b0;
      gnt_wb_q   <= 1'b0;
      cyc_ok_q   <= 1'b0;
      local_q    <= 1'b0;
      cnt_q      <= 8'd0;
      irq_q      <= 1'b0;
      wbs_dat_q  <= 32'd0;
      la_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      la_pend_q  <= la_pend_d;
      last_wb_q  <= last_wb_d;
      gnt_wb_q   <= gnt_wb_d;
      cyc_ok_q   <= cyc_ok_d;
      local_q    <= local_d;
      cnt_q      <= cnt_d;
      irq_q      <= irq_d;
      wbs_dat_q  <= wbs_dat_d;
      la_rdata_q <= la_rdata_d;
    end
  end

  // Request fields are only observed while res_req_o is high, so they carry no reset.
  always_ff @(posedge wb_clk_i) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    sel_q   <= sel_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_user_port_arbiter.sv
// Randomized scoreboard bench for user_port_arbiter: expected resource accesses and
// completions are queued at issue time and consumed by independent monitors.
module tb_user_port_arbiter;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              la_req_i, la_we_i;
  logic [ADDR_W-1:0] la_addr_i;
  logic [31:0]       la_wdata_i;
  logic              la_done_o;
  logic [31:0]       la_rdata_o;
  logic              res_req_o, res_we_o;
  logic [ADDR_W-1:0] res_addr_o;
  logic [3:0]        res_sel_o;
  logic [31:0]       res_wdata_o;
  logic              res_ack_i;
  logic [31:0]       res_rdata_i;
  logic [2:0]        user_irq;

  always #5 wb_clk_i = ~wb_clk_i;

  user_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_req_i(la_req_i), .la_we_i(la_we_i), .la_addr_i(la_addr_i), .la_wdata_i(la_wdata_i),
    .la_done_o(la_done_o), .la_rdata_o(la_rdata_o),
    .res_req_o(res_req_o), .res_we_o(res_we_o), .res_addr_o(res_addr_o),
    .res_sel_o(res_sel_o), .res_wdata_o(res_wdata_o),
    .res_ack_i(res_ack_i), .res_rdata_i(res_rdata_i),
    .user_irq(user_irq)
  );

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        sel;
    logic [31:0]       wdata;
    int                lat;        // cycles of res_req_o before ack; 0 = never
    bit                expect_to;
  } res_exp_t;

  typedef struct {
    bit          is_wb;
    bit          chk_data;
    logic [31:0] data;
  } cpl_t;

  res_exp_t exp_res[$];
  cpl_t     exp_cpl[$];
  int       n_cmp = 0;
  int       n_bad = 0;
  int       ack_cnt = 0;
  int       done_cnt = 0;
  bit       exp_irq = 1'b0;
  bit       noise_en = 1'b0;

  // Resource contents: a fixed function of word address, with one known word.
  function automatic logic [31:0] mem_f(input logic [ADDR_W-1:0] a);
    logic [7:0] b;
    b = 8'(a);
    if (b == 8'h04) return 32'h1234_5678;
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Resource responder: consumes expected accesses and acks after the chosen latency.
  res_exp_t          cur;
  bit                in_req = 1'b0;
  int                rcnt, req_cycles;
  logic [44:0]       snap;

  always @(negedge wb_clk_i) begin
    if (!res_req_o) begin
      if (in_req && cur.expect_to) check("timeout_length", 64'(req_cycles), 64'(TIMEOUT));
      in_req      = 1'b0;
      res_ack_i   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      res_rdata_i = $urandom();
    end else begin
      if (!in_req) begin
        in_req     = 1'b1;
        rcnt       = 0;
        req_cycles = 0;
        if (exp_res.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL res_unexpected: request to addr %0h, none expected", res_addr_o);
          cur.we = res_we_o; cur.addr = res_addr_o; cur.sel = res_sel_o;
          cur.wdata = res_wdata_o; cur.lat = 0; cur.expect_to = 1'b0;
        end else begin
          cur = exp_res.pop_front();
          check("res_we", 64'(res_we_o), 64'(cur.we));
          check("res_addr", 64'(res_addr_o), 64'(cur.addr));
          check("res_sel", 64'(res_sel_o), 64'(cur.sel));
          if (cur.we) check("res_wdata", 64'(res_wdata_o), 64'(cur.wdata));
        end
        snap = {res_we_o, res_addr_o, res_sel_o, res_wdata_o};
      end else begin
        check("res_stable", 64'({res_we_o, res_addr_o, res_sel_o, res_wdata_o}), 64'(snap));
      end
      req_cycles++;
      rcnt++;
      if (cur.lat != 0 && rcnt == cur.lat) begin
        res_ack_i   = 1'b1;
        res_rdata_i = mem_f(res_addr_o);
      end else begin
        res_ack_i   = 1'b0;
        res_rdata_i = $urandom();
      end
    end
  end

  // Completion monitor.
  bit prev_ack = 1'b0, prev_done = 1'b0;
  always @(negedge wb_clk_i) begin
    cpl_t e;
    if (wb_rst_i) begin
      prev_ack  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (wbs_ack_o || la_done_o) begin
        if (wbs_ack_o) ack_cnt++;
        if (la_done_o) done_cnt++;
        check("pulse_width", 64'({prev_ack & wbs_ack_o, prev_done & la_done_o}), 64'd0);
        check("single_completion", 64'(wbs_ack_o & la_done_o), 64'd0);
        if (exp_cpl.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL cpl_unexpected: ack=%0b done=%0b, none expected", wbs_ack_o, la_done_o);
        end else begin
          e = exp_cpl.pop_front();
          check("grant_order", 64'(wbs_ack_o), 64'(e.is_wb));
          if (e.chk_data)
            check(e.is_wb ? "wbs_dat_o" : "la_rdata_o",
                  64'(e.is_wb ? wbs_dat_o : la_rdata_o), 64'(e.data));
        end
      end
      prev_ack  = wbs_ack_o;
      prev_done = la_done_o;
    end
  end

  task automatic wait_cpl(input bit want_wb, input string nm);
    int i;
    for (i = 0; i < 200; i++) begin
      @(posedge wb_clk_i); #1;
      if (want_wb ? wbs_ack_o : la_done_o) break;
    end
    if (i == 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: completion not seen within 200 cycles", nm);
    end
  endtask

  task automatic wait_req(input logic lvl, input string nm);
    int i;
    for (i = 0; i < 200; i++) begin
      if (res_req_o === lvl) break;
      @(posedge wb_clk_i); #1;
    end
    if (i == 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: res_req_o never reached %0b", nm, lvl);
    end
  endtask

  task automatic push_res(input logic we, input int a, input logic [3:0] sel,
                          input logic [31:0] d, input int lat, input bit to);
    res_exp_t r;
    r.we = we; r.addr = a[ADDR_W-1:0]; r.sel = sel; r.wdata = d; r.lat = lat; r.expect_to = to;
    exp_res.push_back(r);
  endtask

  task automatic push_cpl(input bit is_wb, input logic we, input int a, input bit to);
    cpl_t c;
    c.is_wb = is_wb; c.chk_data = !we;
    c.data = to ? 32'hDEAD_BEEF : mem_f(a[ADDR_W-1:0]);
    exp_cpl.push_back(c);
  endtask

  function automatic int word_addr(input logic [31:0] adr);
    return int'(adr >> 2) % (1 << ADDR_W);
  endfunction

  task automatic wb_issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int lat);
    int a;
    bit clr, to;
    a   = word_addr(adr);
    clr = we && dat[31] && (a == (1 << ADDR_W) - 1);
    to  = !clr && (lat == 0 || lat > TIMEOUT);
    if (!clr) push_res(we, a, sel, dat, lat, to);
    push_cpl(1'b1, we, a, to);
    if (to) exp_irq = 1'b1;
    if (clr) exp_irq = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_sel_i = sel; wbs_dat_i = dat;
    wait_cpl(1'b1, "wb_ack");
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("user_irq", 64'(user_irq), 64'({2'b00, exp_irq}));
  endtask

  task automatic la_issue(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] dat, input int lat, input bit hold);
    bit to;
    to = (lat == 0 || lat > TIMEOUT);
    push_res(we, int'(addr), 4'hF, dat, lat, to);
    push_cpl(1'b0, we, int'(addr), to);
    if (to) exp_irq = 1'b1;
    la_we_i = we; la_addr_i = addr; la_wdata_i = dat; la_req_i = 1'b1;
    wait_cpl(1'b0, "la_done");
    if (!hold) la_req_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("user_irq", 64'(user_irq), 64'({2'b00, exp_irq}));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, lat, r;
    logic [31:0] adr, dat;

    wb_rst_i = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;
    la_req_i = 1'b0; la_we_i = 1'b0; la_addr_i = '0; la_wdata_i = 32'd0;
    res_ack_i = 1'b0; res_rdata_i = 32'd0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    check("rst_res_req", 64'(res_req_o), 64'd0);
    check("rst_wbs_ack", 64'(wbs_ack_o), 64'd0);
    check("rst_la_done", 64'(la_done_o), 64'd0);
    check("rst_wbs_dat", 64'(wbs_dat_o), 64'd0);
    check("rst_la_rdata", 64'(la_rdata_o), 64'd0);
    check("rst_user_irq", 64'(user_irq), 64'd0);

    // Simultaneous requests twice: WB must win first, then alternate.
    a0 = ack_cnt; d0 = done_cnt;
    for (int k = 0; k < 2; k++) begin
      push_res(1'b0, 16 + k, 4'h3, 32'd0, 2, 1'b0);
      push_cpl(1'b1, 1'b0, 16 + k, 1'b0);
      push_res(1'b0, 48 + k, 4'hF, 32'd0, 1, 1'b0);
      push_cpl(1'b0, 1'b0, 48 + k, 1'b0);
      la_we_i = 1'b0; la_addr_i = 8'(48 + k); la_req_i = 1'b1;
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
      wbs_adr_i = 32'((16 + k) * 4); wbs_sel_i = 4'h3;
      wait_cpl(1'b1, "rr_wb_ack");
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      wait_cpl(1'b0, "rr_la_done");
      la_req_i = 1'b0;
      @(posedge wb_clk_i); #1;
    end
    check("rr_wb_acks", 64'(ack_cnt - a0), 64'd2);
    check("rr_la_dones", 64'(done_cnt - d0), 64'd2);

    // WB read of byte address 0x10, acked two cycles after the request rises.
    wb_issue(1'b0, 32'h0000_0010, 4'hF, 32'd0, 3);

    // Timeout, sticky IRQ, then the clearing write.
    wb_issue(1'b0, 32'h0000_0020, 4'hF, 32'd0, 0);
    wb_issue(1'b0, 32'h0000_0024, 4'hF, 32'd0, 2);
    wb_issue(1'b1, 32'h0000_03FC, 4'hF, 32'h8000_0000, 1);

    // LA write with la_req_i held high afterwards.
    d0 = done_cnt;
    la_issue(1'b1, 8'h3F, 32'hA5A5_A5A5, 2, 1'b1);
    repeat (10) @(posedge wb_clk_i);
    #1 check("la_hold_single_done", 64'(done_cnt - d0), 64'd1);
    la_req_i = 1'b0;
    @(posedge wb_clk_i); #1;

    // Master abandons the cycle mid-BUSY.
    a0 = ack_cnt;
    push_res(1'b0, word_addr(32'h88), 4'hF, 32'd0, 5, 1'b0);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h88; wbs_sel_i = 4'hF;
    wait_req(1'b1, "cycdrop_req_rise");
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    wait_req(1'b0, "cycdrop_req_fall");
    repeat (4) @(posedge wb_clk_i);
    #1 check("cycdrop_no_ack", 64'(ack_cnt - a0), 64'd0);

    // Reset in the middle of a resource access.
    a0 = ack_cnt;
    push_res(1'b0, word_addr(32'h50), 4'hF, 32'd0, 100, 1'b0);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h50; wbs_sel_i = 4'hF;
    wait_req(1'b1, "rst_busy_req");
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("rst_busy_res_req", 64'(res_req_o), 64'd0);
    check("rst_busy_ack", 64'(wbs_ack_o), 64'd0);
    check("rst_busy_irq", 64'(user_irq), 64'd0);
    exp_irq = 1'b0;
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("rst_busy_no_ack_count", 64'(ack_cnt - a0), 64'd0);
    wb_issue(1'b0, 32'h0000_0054, 4'hF, 32'd0, 2);

    // Randomized mix with stray res_ack_i outside BUSY.
    noise_en = 1'b1;
    for (int t = 0; t < 80; t++) begin
      r = int'($urandom_range(0, 19));
      if (r < 14)      lat = 1 + r % 4;
      else if (r < 16) lat = TIMEOUT;
      else if (r < 18) lat = 0;
      else             lat = TIMEOUT + 1;
      dat = $urandom();
      if ($urandom_range(0, 1) == 0) begin
        adr = $urandom();
        if ($urandom_range(0, 5) == 0) adr = (adr & 32'hFFFF_FC00) | 32'h0000_03FC;
        wb_issue(1'($urandom_range(0, 1)), adr, 4'($urandom_range(0, 15)), dat, lat);
      end else begin
        la_issue(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 255)), dat, lat, 1'b0);
      end
    end
    noise_en = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("exp_cpl_drained", 64'(exp_cpl.size()), 64'd0);
    check("exp_res_drained", 64'(exp_res.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
